// File: rtl/silife_grid_sched_if.sv
// -----------------------------------------------------------------------------
// silife_grid_sched_if
// Bundles the two loader write handshakes and the grid control bus that the
// Life-grid scheduler owns.
//
// Signals
//   host_req/host_row/host_cells   host loader write request, row, row data
//   host_ack                       1-cycle: host write performed this cycle
//   demo_req/demo_row/demo_cells   demo loader write request, row, row data
//   demo_ack                       1-cycle: demo write performed this cycle
//   row_select/cells               grid row address and data (registered)
//   wr_en                          grid write strobe (registered)
//   step                           grid generation step pulse (registered)
//
// Modports
//   master  requester side: drives requests, observes acks and grid bus
//   slave   scheduler side: takes requests, drives acks and grid bus
// -----------------------------------------------------------------------------
interface silife_grid_sched_if #(
   parameter int ROW_W = 5,
   parameter int COL_W = 8
);
   logic             host_req;
   logic [ROW_W-1:0] host_row;
   logic [COL_W-1:0] host_cells;
   logic             host_ack;

   logic             demo_req;
   logic [ROW_W-1:0] demo_row;
   logic [COL_W-1:0] demo_cells;
   logic             demo_ack;

   logic [ROW_W-1:0] row_select;
   logic [COL_W-1:0] cells;
   logic             wr_en;
   logic             step;

   modport master (
      output host_req, host_row, host_cells,
      output demo_req, demo_row, demo_cells,
      input  host_ack, demo_ack,
      input  row_select, cells, wr_en, step
   );

   modport slave (
      input  host_req, host_row, host_cells,
      input  demo_req, demo_row, demo_cells,
      output host_ack, demo_ack,
      output row_select, cells, wr_en, step
   );
endinterface

// File: rtl/silife_grid_sched.sv
// -----------------------------------------------------------------------------
// silife_grid_sched
// Scheduler for the shared Life-grid control port. Arbitrates row writes
// between the host loader and the demo loader (host wins) and times generation
// steps: free-running period while run=1, plus single-step requests. It is the
// only driver of the grid wr_en/step strobes.
//
// Ports
//   clk           clock
//   rst_n         synchronous, active-low reset
//   en            global enable; 0 freezes the scheduler
//   run           1 = auto-step every STEP_PERIOD cycles
//   single_step   1-cycle pulse requesting one step
//   bus           silife_grid_sched_if.slave (loader handshakes + grid bus)
//   step_dropped  1-cycle: step request merged into an already-pending one
//   gen_count     generations issued since the last write (optional)
//
// Optional feature
//   SILIFE_GEN_COUNT_EN  defined: gen_count counts step pulses, wraps at
//                        16'hFFFF, cleared by reset and by any grid write.
//                        undefined: gen_count tied to zero, no counter flops.
// -----------------------------------------------------------------------------
module silife_grid_sched #(
   parameter int STEP_PERIOD = 4_000_000,
   parameter int CNT_W       = 32,
   parameter int ROW_W       = 5,
   parameter int COL_W       = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                run,
   input  logic                single_step,
   silife_grid_sched_if.slave  bus,
   output logic                step_dropped,
   output logic [15:0]         gen_count
);

   logic [CNT_W-1:0] period_cnt;
   logic             step_pending;

   logic             host_ack_q;
   logic             demo_ack_q;
   logic             wr_en_q;
   logic             step_q;
   logic             drop_q;
   logic [ROW_W-1:0] row_q;
   logic [COL_W-1:0] cells_q;

   logic             ack_busy;
   logic             grant_host;
   logic             grant_demo;
   logic             grant_any;
   logic             tick;
   logic             step_req;
   logic             step_issue;

   // A cycle with an ack high is the requester's last cycle of holding its
   // request, so no grant is evaluated then; this keeps writes at least two
   // cycles apart and stops a held request from being written twice. Steps
   // only go out when no write is being granted or acknowledged.
   always_comb begin
      ack_busy   = host_ack_q | demo_ack_q;
      grant_host = en & ~ack_busy & bus.host_req;
      grant_demo = en & ~ack_busy & ~bus.host_req & bus.demo_req;
      grant_any  = grant_host | grant_demo;
      tick       = en & run & (period_cnt == CNT_W'(STEP_PERIOD - 1));
      step_req   = tick | (en & single_step);
      step_issue = en & step_pending & ~grant_any & ~ack_busy;
   end

   // Registered grid bus, acks and step bookkeeping. A step request arriving
   // while one is still pending (and not being issued now) merges into it and
   // is reported through step_dropped. With en=0 all strobes fall to zero but
   // the pending step and the period count are kept.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         period_cnt   <= '0;
         step_pending <= 1'b0;
         host_ack_q   <= 1'b0;
         demo_ack_q   <= 1'b0;
         wr_en_q      <= 1'b0;
         step_q       <= 1'b0;
         drop_q       <= 1'b0;
         row_q        <= '0;
         cells_q      <= '0;
      end else begin
         wr_en_q    <= grant_any;
         host_ack_q <= grant_host;
         demo_ack_q <= grant_demo;
         if (grant_host) begin
            row_q   <= bus.host_row;
            cells_q <= bus.host_cells;
         end else if (grant_demo) begin
            row_q   <= bus.demo_row;
            cells_q <= bus.demo_cells;
         end
         step_q       <= step_issue;
         drop_q       <= step_req & step_pending & ~step_issue;
         step_pending <= (step_pending & ~step_issue) | step_req;
         if (en & run) begin
            period_cnt <= tick ? '0 : period_cnt + CNT_W'(1);
         end
      end
   end

`ifdef SILIFE_GEN_COUNT_EN
   logic [15:0] gen_q;

   // Generation counter restarts whenever a new pattern row is written.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gen_q <= 16'd0;
      end else if (wr_en_q) begin
         gen_q <= 16'd0;
      end else if (step_q) begin
         gen_q <= gen_q + 16'd1;
      end
   end

   assign gen_count = gen_q;
`else
   assign gen_count = 16'd0;
`endif

   assign bus.host_ack   = host_ack_q;
   assign bus.demo_ack   = demo_ack_q;
   assign bus.wr_en      = wr_en_q;
   assign bus.step       = step_q;
   assign bus.row_select = row_q;
   assign bus.cells      = cells_q;
   assign step_dropped   = drop_q;

endmodule

// File: tb/tb_silife_grid_sched.sv
// -----------------------------------------------------------------------------
// tb_silife_grid_sched
// Self-checking bench for silife_grid_sched with STEP_PERIOD=4. A table of
// {inputs, expected outputs} vectors covers arbitration and step merging,
// hand-written sequences cover the multi-cycle cases (demo row sweep, enable
// freeze, auto-step period, reset during a write), and a randomized phase
// compares every cycle against a behavioural model of the scheduling rules.
// Honours SILIFE_GEN_COUNT_EN when defined for the expected gen_count.
// -----------------------------------------------------------------------------
module tb_silife_grid_sched;

   localparam int STEP_PERIOD = 4;
   localparam int ROW_W       = 5;
   localparam int COL_W       = 8;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        run;
   logic        single_step;
   logic        step_dropped;
   logic [15:0] gen_count;

   int checks;
   int errors;

   silife_grid_sched_if #(.ROW_W(ROW_W), .COL_W(COL_W)) bus ();

   silife_grid_sched #(
      .STEP_PERIOD (STEP_PERIOD),
      .CNT_W       (32),
      .ROW_W       (ROW_W),
      .COL_W       (COL_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .run          (run),
      .single_step  (single_step),
      .bus          (bus),
      .step_dropped (step_dropped),
      .gen_count    (gen_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state
   int         m_cnt;
   bit         m_pending;
   bit         m_wr, m_step, m_hack, m_dack, m_drop;
   logic [4:0] m_row;
   logic [7:0] m_cells;
   int         m_gen;

   typedef struct {
      logic       en, run, ss, hreq;
      logic [4:0] hrow;
      logic [7:0] hcells;
      logic       dreq;
      logic [4:0] drow;
      logic [7:0] dcells;
      logic       ewr, estep, ehack, edack, edrop;
      logic [4:0] erow;
      logic [7:0] ecells;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One clock edge of the scheduling rules, applied to the inputs seen at it.
   task automatic model_update();
      bit busy, tick, want, fire;
      int winner;
      if (!rst_n) begin
         m_cnt = 0; m_pending = 0; m_wr = 0; m_step = 0; m_hack = 0;
         m_dack = 0; m_drop = 0; m_row = '0; m_cells = '0; m_gen = 0;
         return;
      end
      busy   = m_hack || m_dack;
      winner = 0;
      if (en && !busy) winner = bus.host_req ? 1 : (bus.demo_req ? 2 : 0);
      tick = en && run && (m_cnt == STEP_PERIOD - 1);
      want = tick || (en && single_step);
      fire = en && m_pending && (winner == 0) && !busy;
`ifdef SILIFE_GEN_COUNT_EN
      if (m_wr) m_gen = 0;
      else if (m_step) m_gen = (m_gen + 1) % 65536;
`endif
      m_drop    = want && m_pending && !fire;
      m_pending = (m_pending && !fire) || want;
      if (en && run) m_cnt = (m_cnt + 1) % STEP_PERIOD;
      m_step = fire;
      m_wr   = (winner != 0);
      m_hack = (winner == 1);
      m_dack = (winner == 2);
      if (winner == 1) begin
         m_row = bus.host_row; m_cells = bus.host_cells;
      end else if (winner == 2) begin
         m_row = bus.demo_row; m_cells = bus.demo_cells;
      end
   endtask

   // Advance one cycle and compare the whole output set against the model.
   task automatic clock_cycle();
      @(posedge clk);
      model_update();
      #1;
      check("model_outputs",
            32'({bus.wr_en, bus.step, bus.host_ack, bus.demo_ack, step_dropped,
                 bus.row_select, bus.cells}),
            32'({m_wr, m_step, m_hack, m_dack, m_drop, m_row, m_cells}));
      check("model_gen_count", 32'(gen_count), 32'(m_gen));
   endtask

   task automatic idle_inputs();
      en = 1'b1; run = 1'b0; single_step = 1'b0;
      bus.host_req = 1'b0; bus.host_row = '0; bus.host_cells = '0;
      bus.demo_req = 1'b0; bus.demo_row = '0; bus.demo_cells = '0;
   endtask

   task automatic apply_stimulus(input vec_t v);
      en = v.en; run = v.run; single_step = v.ss;
      bus.host_req = v.hreq; bus.host_row = v.hrow; bus.host_cells = v.hcells;
      bus.demo_req = v.dreq; bus.demo_row = v.drow; bus.demo_cells = v.dcells;
      clock_cycle();
   endtask

   task automatic check_output(input vec_t v);
      check("vec_wr_en",    32'(bus.wr_en),      32'(v.ewr));
      check("vec_step",     32'(bus.step),       32'(v.estep));
      check("vec_host_ack", 32'(bus.host_ack),   32'(v.ehack));
      check("vec_demo_ack", 32'(bus.demo_ack),   32'(v.edack));
      check("vec_dropped",  32'(step_dropped),   32'(v.edrop));
      check("vec_row",      32'(bus.row_select), 32'(v.erow));
      check("vec_cells",    32'(bus.cells),      32'(v.ecells));
   endtask

   initial begin
      logic [7:0] data;
      logic       exp_step;
      bit         h_drop, d_drop;
      logic [15:0] exp_gen;

      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      idle_inputs();

      // en run ss hreq hrow hcells dreq drow dcells | wr step hack dack drop row cells
      vecs[0]  = '{1,0,0,1,5'd3,8'hA5,1,5'd7,8'h3C, 1,0,1,0,0,5'd3,8'hA5};
      vecs[1]  = '{1,0,0,1,5'd3,8'hA5,1,5'd7,8'h3C, 0,0,0,0,0,5'd3,8'hA5};
      vecs[2]  = '{1,0,0,0,5'd0,8'h00,1,5'd7,8'h3C, 1,0,0,1,0,5'd7,8'h3C};
      vecs[3]  = '{1,0,0,0,5'd0,8'h00,1,5'd7,8'h3C, 0,0,0,0,0,5'd7,8'h3C};
      vecs[4]  = '{1,0,0,0,5'd0,8'h00,0,5'd0,8'h00, 0,0,0,0,0,5'd7,8'h3C};
      vecs[5]  = '{1,0,1,1,5'd1,8'h11,0,5'd0,8'h00, 1,0,1,0,0,5'd1,8'h11};
      vecs[6]  = '{1,0,1,1,5'd1,8'h11,0,5'd0,8'h00, 0,0,0,0,1,5'd1,8'h11};
      vecs[7]  = '{1,0,0,1,5'd2,8'h22,0,5'd0,8'h00, 1,0,1,0,0,5'd2,8'h22};
      vecs[8]  = '{1,0,0,1,5'd2,8'h22,0,5'd0,8'h00, 0,0,0,0,0,5'd2,8'h22};
      vecs[9]  = '{1,0,0,0,5'd0,8'h00,0,5'd0,8'h00, 0,1,0,0,0,5'd2,8'h22};
      vecs[10] = '{1,0,0,0,5'd0,8'h00,0,5'd0,8'h00, 0,0,0,0,0,5'd2,8'h22};

      // Reset state
      clock_cycle();
      clock_cycle();
      check("reset_wr_en", 32'(bus.wr_en), 32'd0);
      check("reset_step",  32'(bus.step),  32'd0);
      check("reset_row",   32'(bus.row_select), 32'd0);
      check("reset_gen",   32'(gen_count), 32'd0);
      rst_n = 1'b1;
      clock_cycle();

      // Arbitration with gap cycle, then single-steps blocked by writes
      foreach (vecs[i]) begin
         apply_stimulus(vecs[i]);
         check_output(vecs[i]);
      end

      // Demo loader sweeps all 32 rows at two-cycle spacing
      idle_inputs();
      for (int r = 0; r < 32; r++) begin
         data = 8'($urandom);
         bus.demo_req = 1'b1; bus.demo_row = 5'(r); bus.demo_cells = data;
         clock_cycle();
         check("sweep_write", 32'({bus.wr_en, bus.demo_ack, bus.host_ack}), 32'b110);
         check("sweep_row",   32'(bus.row_select), 32'(r));
         check("sweep_cells", 32'(bus.cells), 32'(data));
         clock_cycle();
         check("sweep_gap",   32'({bus.wr_en, bus.demo_ack}), 32'b00);
      end
      idle_inputs();
      clock_cycle();

      // Step held through en=0, issued right after re-enable
      bus.host_req = 1'b1; bus.host_row = 5'd9; bus.host_cells = 8'h5A;
      single_step = 1'b1;
      clock_cycle();
      check("freeze_write", 32'(bus.wr_en), 32'd1);
      single_step = 1'b0;
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 1) bus.host_req = 1'b0;
         clock_cycle();
         check("freeze_no_step", 32'({bus.step, bus.wr_en}), 32'd0);
      end
      en = 1'b1;
      clock_cycle();
      check("resume_step", 32'(bus.step), 32'd1);
      clock_cycle();
      check("resume_step_done", 32'(bus.step), 32'd0);
`ifdef SILIFE_GEN_COUNT_EN
      exp_gen = 16'd1;
`else
      exp_gen = 16'd0;
`endif
      check("gen_after_step", 32'(gen_count), 32'(exp_gen));
      bus.host_req = 1'b1; bus.host_row = 5'd4; bus.host_cells = 8'h0F;
      clock_cycle();
      check("gen_clear_write", 32'(bus.wr_en), 32'd1);
      clock_cycle();
      bus.host_req = 1'b0;
      check("gen_cleared", 32'(gen_count), 32'd0);

      // Auto-step period: the first edge with rst_n high is edge 1, so steps
      // appear after edges 5, 9 and 13 (cycles 4, 8, 12 counting from 0).
      rst_n = 1'b0;
      clock_cycle();
      clock_cycle();
      rst_n = 1'b1;
      run   = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         clock_cycle();
         exp_step = (k >= 5) && (k % 4 == 1);
         check("period_step",  32'(bus.step),  32'(exp_step));
         check("period_no_wr", 32'(bus.wr_en), 32'd0);
      end
      run = 1'b0;

      // Reset during a write: the held request is granted again afterwards
      bus.host_req = 1'b1; bus.host_row = 5'd21; bus.host_cells = 8'hC3;
      clock_cycle();
      check("midreset_write", 32'({bus.wr_en, bus.row_select}), 32'({1'b1, 5'd21}));
      rst_n = 1'b0;
      clock_cycle();
      check("midreset_cleared", 32'({bus.wr_en, bus.host_ack, bus.row_select}), 32'd0);
      rst_n = 1'b1;
      clock_cycle();
      check("midreset_regrant", 32'({bus.wr_en, bus.host_ack, bus.row_select, bus.cells}),
            32'({1'b1, 1'b1, 5'd21, 8'hC3}));
      clock_cycle();
      bus.host_req = 1'b0;

      // Randomized traffic; loaders hold each request until its ack cycle ends
      h_drop = 1'b0;
      d_drop = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (m_hack) begin
            h_drop = 1'b1;
         end else if (!bus.host_req || h_drop) begin
            h_drop = 1'b0;
            bus.host_req   = ($urandom_range(0, 3) == 0);
            bus.host_row   = 5'($urandom);
            bus.host_cells = 8'($urandom);
         end
         if (m_dack) begin
            d_drop = 1'b1;
         end else if (!bus.demo_req || d_drop) begin
            d_drop = 1'b0;
            bus.demo_req   = ($urandom_range(0, 2) == 0);
            bus.demo_row   = 5'($urandom);
            bus.demo_cells = 8'($urandom);
         end
         en          = ($urandom_range(0, 9) != 0);
         single_step = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 49) == 0) run = ~run;
         rst_n       = ($urandom_range(0, 199) != 0);
         clock_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
